// File: rtl/quad_gen_pkg.sv
// Shared types and constants for the quadrature step generator.
// Holds the FSM state enum, the CW/CCW phase tables, idle levels and bounce length.
package quad_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_PRESS  = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

   // Phase tables, index 0 in the low bits; each entry is {A,B}
   localparam logic [7:0] CW_SEQ  = 8'b11_10_00_01;
   localparam logic [7:0] CCW_SEQ = 8'b11_01_00_10;

   localparam logic [1:0]  IDLE_AB    = 2'b11;
   localparam logic        IDLE_C     = 1'b1;
   localparam int unsigned BOUNCE_LEN = 4;

   function automatic logic [1:0] phase_ab(input logic cw, input logic [1:0] idx);
      logic [7:0] seq;
      seq = cw ? CW_SEQ : CCW_SEQ;
      return seq[{idx, 1'b0} +: 2];
   endfunction

   // True when hold offset k falls on an "old level" slot of the bounce burst
   function automatic logic bounce_odd(input int unsigned k);
      return (k < BOUNCE_LEN) && k[0];
   endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// Hold-time down-counter for quadrature phases and press/gap intervals.
// With QUAD_STEP_GEN_BOUNCE_EN it also flags the bounce slots that follow each load.
module quad_phase_timer
   import quad_gen_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
`ifdef QUAD_STEP_GEN_BOUNCE_EN
   output logic         bounce_odd_c,
`endif
   output logic         expire_c
);

   logic [W-1:0] cnt;

   // Loaded with hold-1 so expiry lines up with the edge that ends the hold
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val - W'(1);
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expire_c = (cnt == '0);

`ifdef QUAD_STEP_GEN_BOUNCE_EN
   logic [W-1:0] len_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q <= '0;
      end else if (load) begin
         len_q <= load_val;
      end
   end

   // len_q - cnt is the hold offset of the cycle that follows the next edge
   assign bounce_odd_c = bounce_odd(32'(len_q - cnt));
`endif

endmodule

// File: rtl/quad_step_gen.sv
// Quadrature rotary-encoder transmitter: emits detent steps and push presses on Rot_A/B/C.
// Define QUAD_STEP_GEN_BOUNCE_EN to add a new/old/new/old glitch burst on every output transition.
module quad_step_gen
   import quad_gen_pkg::*;
#(
   parameter int unsigned PHASE_CYC = 16,
   parameter int unsigned PRESS_CYC = 64,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             Fg_CLK,
   input  logic             RESET,
   input  logic             Cmd_Valid,
   output logic             Cmd_Ready,
   input  logic             Cmd_Press,
   input  logic             Cmd_Dir,
   input  logic [CNT_W-1:0] Cmd_Steps,
   output logic             Rot_A,
   output logic             Rot_B,
   output logic             Rot_C,
   output logic             Busy,
   output logic [CNT_W-1:0] Steps_Left,
   output logic             Done
);

   localparam int unsigned HOLD_MAX = (PHASE_CYC > PRESS_CYC) ? PHASE_CYC : PRESS_CYC;
   localparam int unsigned TMR_W    = $clog2(HOLD_MAX + 1);

   state_e           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic             dir_q, dir_d;
   logic [1:0]       ab_q, ab_d;
   logic             c_q, c_d;
   logic [CNT_W-1:0] steps_d;
   logic             done_d;
   logic             busy_d;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             expire_c;
   logic             accept_c;
   logic             last_step_c;

   assign accept_c    = Cmd_Valid && Cmd_Ready;
   assign last_step_c = expire_c && (phase_q == 2'd3) && (Steps_Left == CNT_W'(1));

`ifdef QUAD_STEP_GEN_BOUNCE_EN
   logic bounce_odd_c;
`endif

   quad_phase_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk          (Fg_CLK),
      .reset        (RESET),
      .load         (tmr_load),
      .load_val     (tmr_val),
`ifdef QUAD_STEP_GEN_BOUNCE_EN
      .bounce_odd_c (bounce_odd_c),
`endif
      .expire_c     (expire_c)
   );

   // State and clean output registers; RESET wins over any accept
   always_ff @(posedge Fg_CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         dir_q      <= 1'b0;
         ab_q       <= IDLE_AB;
         c_q        <= IDLE_C;
         Steps_Left <= '0;
         Done       <= 1'b0;
         Busy       <= 1'b0;
         Cmd_Ready  <= 1'b1;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         dir_q      <= dir_d;
         ab_q       <= ab_d;
         c_q        <= c_d;
         Steps_Left <= steps_d;
         Done       <= done_d;
         Busy       <= busy_d;
         Cmd_Ready  <= !busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (Cmd_Press) begin
                  state_d = ST_PRESS;
               end else if (Cmd_Steps != '0) begin
                  state_d = ST_ROTATE;
               end
            end
         end
         ST_ROTATE: if (last_step_c) state_d = ST_IDLE;
         ST_PRESS:  if (expire_c)    state_d = ST_GAP;
         ST_GAP:    if (expire_c)    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values for the phase index, step count, pin levels and timer reloads
   always_comb begin
      phase_d  = phase_q;
      dir_d    = dir_q;
      ab_d     = ab_q;
      c_d      = c_q;
      steps_d  = Steps_Left;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = TMR_W'(PHASE_CYC);
      case (state_q)
         ST_IDLE: begin
            steps_d = '0;
            if (accept_c) begin
               if (Cmd_Press) begin
                  c_d      = ~IDLE_C;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(PRESS_CYC);
               end else if (Cmd_Steps != '0) begin
                  steps_d  = Cmd_Steps;
                  dir_d    = Cmd_Dir;
                  phase_d  = 2'd0;
                  ab_d     = phase_ab(Cmd_Dir, 2'd0);
                  tmr_load = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_ROTATE: begin
            if (expire_c) begin
               if (phase_q == 2'd3) begin
                  steps_d = Steps_Left - CNT_W'(1);
                  if (Steps_Left == CNT_W'(1)) begin
                     done_d = 1'b1;
                  end else begin
                     phase_d  = 2'd0;
                     ab_d     = phase_ab(dir_q, 2'd0);
                     tmr_load = 1'b1;
                  end
               end else begin
                  phase_d  = phase_q + 2'd1;
                  ab_d     = phase_ab(dir_q, phase_q + 2'd1);
                  tmr_load = 1'b1;
               end
            end
         end
         ST_PRESS: begin
            if (expire_c) begin
               c_d      = IDLE_C;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(PRESS_CYC);
            end
         end
         ST_GAP: begin
            if (expire_c) done_d = 1'b1;
         end
         default: ;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

`ifdef QUAD_STEP_GEN_BOUNCE_EN
   logic [2:0] mask_q;

   // Pins follow the clean levels except on odd bounce slots, where the changed line reverts
   always_ff @(posedge Fg_CLK) begin
      if (RESET) begin
         mask_q <= '0;
         Rot_A  <= IDLE_AB[1];
         Rot_B  <= IDLE_AB[0];
         Rot_C  <= IDLE_C;
      end else if ({ab_d, c_d} != {ab_q, c_q}) begin
         mask_q                <= {ab_d, c_d} ^ {ab_q, c_q};
         {Rot_A, Rot_B, Rot_C} <= {ab_d, c_d};
      end else begin
         {Rot_A, Rot_B, Rot_C} <= {ab_q, c_q} ^ (mask_q & {3{bounce_odd_c}});
      end
   end
`else
   assign Rot_A = ab_q[1];
   assign Rot_B = ab_q[0];
   assign Rot_C = c_q;
`endif

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: vector table, hand sequences and random commands
// compared cycle by cycle against a waveform model derived from the step/press timing rules.
module tb_quad_step_gen;

   localparam int P  = 16;
   localparam int PR = 64;

   logic       Fg_CLK = 1'b0;
   logic       RESET;
   logic       Cmd_Valid;
   logic       Cmd_Ready;
   logic       Cmd_Press;
   logic       Cmd_Dir;
   logic [7:0] Cmd_Steps;
   logic       Rot_A, Rot_B, Rot_C;
   logic       Busy;
   logic [7:0] Steps_Left;
   logic       Done;

   quad_step_gen #(
      .PHASE_CYC (P),
      .PRESS_CYC (PR),
      .CNT_W     (8)
   ) dut (
      .Fg_CLK     (Fg_CLK),
      .RESET      (RESET),
      .Cmd_Valid  (Cmd_Valid),
      .Cmd_Ready  (Cmd_Ready),
      .Cmd_Press  (Cmd_Press),
      .Cmd_Dir    (Cmd_Dir),
      .Cmd_Steps  (Cmd_Steps),
      .Rot_A      (Rot_A),
      .Rot_B      (Rot_B),
      .Rot_C      (Rot_C),
      .Busy       (Busy),
      .Steps_Left (Steps_Left),
      .Done       (Done)
   );

   always #5 Fg_CLK = ~Fg_CLK;

   typedef struct {
      logic press;
      logic dir;
      int   steps;
   } cmd_t;

   typedef struct packed {
      logic       a;
      logic       b;
      logic       c;
      logic       ready;
      logic       busy;
      logic       done;
      logic [7:0] steps;
   } obs_t;

   typedef struct {
      cmd_t cmd;
      int   exp_t;
      int   exp_q;
   } vec_t;

   int         checks   = 0;
   int         failures = 0;
   int         quarters = 0;
   logic [1:0] dec_prev = 2'b11;
   int         seq_cw[4]  = '{1, 0, 2, 3};
   int         seq_ccw[4] = '{2, 0, 1, 3};

   function automatic cmd_t mkcmd(logic p, logic d, int s);
      cmd_t c;
      c.press = p;
      c.dir   = d;
      c.steps = s;
      return c;
   endfunction

   function automatic int seq_code(logic dir, int j);
      return dir ? seq_cw[j] : seq_ccw[j];
   endfunction

   function automatic obs_t idle_obs();
      obs_t e;
      e = '{a: 1'b1, b: 1'b1, c: 1'b1, ready: 1'b1, busy: 1'b0, done: 1'b0, steps: 8'd0};
      return e;
   endfunction

   function automatic int done_cycle(cmd_t c);
      if (c.press) return 2 * PR + 1;
      if (c.steps == 0) return 1;
      return 4 * c.steps * P + 1;
   endfunction

   // Expected outputs in cycle t after the accepting edge (t = 1 is the first cycle after it)
   function automatic obs_t model(cmd_t c, int t);
      obs_t       e;
      int         j, k, total;
      logic [1:0] abv;
      logic       bounce;
`ifdef QUAD_STEP_GEN_BOUNCE_EN
      bounce = 1'b1;
`else
      bounce = 1'b0;
`endif
      e = idle_obs();
      if (c.press) begin
         if (t <= 2 * PR) begin
            e.busy  = 1'b1;
            e.ready = 1'b0;
            e.c     = (t > PR);
            k       = (t - 1) % PR;
            if (bounce && (k == 1 || k == 3)) e.c = ~e.c;
         end else if (t == 2 * PR + 1) begin
            e.done = 1'b1;
         end
      end else if (c.steps == 0) begin
         if (t == 1) e.done = 1'b1;
      end else begin
         total = 4 * c.steps * P;
         if (t <= total) begin
            e.busy  = 1'b1;
            e.ready = 1'b0;
            j       = (t - 1) / P;
            k       = (t - 1) % P;
            abv     = 2'(seq_code(c.dir, j % 4));
            if (bounce && (k == 1 || k == 3))
               abv = (j == 0) ? 2'b11 : 2'(seq_code(c.dir, (j - 1) % 4));
            e.a     = abv[1];
            e.b     = abv[0];
            e.steps = 8'(c.steps - (t - 1) / (4 * P));
         end else if (t == total + 1) begin
            e.done = 1'b1;
         end
      end
      return e;
   endfunction

   function automatic int qpos(logic [1:0] ab);
      case (ab)
         2'b11:   return 0;
         2'b01:   return 1;
         2'b00:   return 2;
         default: return 3;
      endcase
   endfunction

   // Compare one cycle of outputs and feed the bench's quadrature decoder
   task automatic check(input string name, input int t, input obs_t exp);
      obs_t       got;
      logic [1:0] cur;
      int         d;
      got = '{a: Rot_A, b: Rot_B, c: Rot_C, ready: Cmd_Ready, busy: Busy, done: Done,
              steps: Steps_Left};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got{A,B,C,rdy,busy,done,steps}=%b exp=%b", name, t, got, exp);
      end
      cur = {Rot_A, Rot_B};
      if (cur != dec_prev) begin
         d = (qpos(cur) - qpos(dec_prev) + 4) % 4;
         checks++;
         if (d == 2) begin
            failures++;
            $display("FAIL %s_gray t=%0d got ab %b->%b exp single-line change", name, t, dec_prev, cur);
         end else begin
            quarters += (d == 1) ? 1 : -1;
         end
         dec_prev = cur;
      end
   endtask

   task automatic idle_cycles(input int n, input string name);
      Cmd_Valid = 1'b0;
      repeat (n) begin
         @(negedge Fg_CLK);
         check(name, 0, idle_obs());
      end
   endtask

   // Present a command, then check every cycle up to its Done (or stop_t for an aborted run)
   task automatic run_cmd(input cmd_t c, input logic hold, input cmd_t nxt, input int stop_t,
                          input int exp_t, input int exp_q, input string name);
      int limit, q0, seen;
      limit     = (stop_t > 0) ? stop_t : done_cycle(c);
      q0        = quarters;
      seen      = -1;
      Cmd_Valid = 1'b1;
      Cmd_Press = c.press;
      Cmd_Dir   = c.dir;
      Cmd_Steps = 8'(c.steps);
      @(posedge Fg_CLK);
      for (int t = 1; t <= limit; t++) begin
         @(negedge Fg_CLK);
         if (t == 1) begin
            if (hold) begin
               Cmd_Press = nxt.press;
               Cmd_Dir   = nxt.dir;
               Cmd_Steps = 8'(nxt.steps);
            end else begin
               Cmd_Valid = 1'b0;
            end
         end
         check(name, t, model(c, t));
         if (Done && seen < 0) seen = t;
      end
      if (stop_t == 0) begin
         checks++;
         if (seen != exp_t) begin
            failures++;
            $display("FAIL %s_done_lat got=%0d exp=%0d", name, seen, exp_t);
         end
         checks++;
         if (quarters - q0 != exp_q) begin
            failures++;
            $display("FAIL %s_decoder got=%0d exp=%0d quarter steps", name, quarters - q0, exp_q);
         end
      end
   endtask

   function automatic int exp_quarters(cmd_t c);
      if (c.press || c.steps == 0) return 0;
      return c.dir ? 4 * c.steps : -4 * c.steps;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      cmd_t none, cur, nxt;
      logic hold;

      none      = mkcmd(1'b0, 1'b0, 0);
      RESET     = 1'b1;
      Cmd_Valid = 1'b0;
      Cmd_Press = 1'b0;
      Cmd_Dir   = 1'b0;
      Cmd_Steps = 8'd0;
      repeat (2) @(negedge Fg_CLK);
      check("reset", 0, idle_obs());
      RESET = 1'b0;
      idle_cycles(3, "idle");

      vecs[0] = '{cmd: mkcmd(1'b0, 1'b1, 2),   exp_t: 129,   exp_q: 8};
      vecs[1] = '{cmd: mkcmd(1'b0, 1'b0, 1),   exp_t: 65,    exp_q: -4};
      vecs[2] = '{cmd: mkcmd(1'b1, 1'b0, 0),   exp_t: 129,   exp_q: 0};
      vecs[3] = '{cmd: mkcmd(1'b0, 1'b1, 0),   exp_t: 1,     exp_q: 0};
      vecs[4] = '{cmd: mkcmd(1'b0, 1'b0, 3),   exp_t: 193,   exp_q: -12};
      vecs[5] = '{cmd: mkcmd(1'b0, 1'b1, 255), exp_t: 16321, exp_q: 1020};
      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].cmd, 1'b0, none, 0, vecs[i].exp_t, vecs[i].exp_q, "vec");
         idle_cycles(1, "vec_idle");
      end

      // Second command held while busy, then taken back-to-back
      cur = mkcmd(1'b0, 1'b1, 1);
      nxt = mkcmd(1'b0, 1'b0, 2);
      run_cmd(cur, 1'b1, nxt, 0, 65, 4, "held");
      run_cmd(nxt, 1'b0, none, 0, 129, -8, "b2b");
      idle_cycles(2, "b2b_idle");

      // Reset mid-step with a command also presented
      run_cmd(mkcmd(1'b0, 1'b1, 2), 1'b0, none, 40, 0, 0, "partial");
      RESET     = 1'b1;
      Cmd_Valid = 1'b1;
      Cmd_Press = 1'b1;
      @(negedge Fg_CLK);
      dec_prev = 2'b11;
      check("rst_mid", 0, idle_obs());
      RESET = 1'b0;
      idle_cycles(5, "post_rst");

      // Reset beats acceptance of a command presented in the same cycle
      RESET     = 1'b1;
      Cmd_Valid = 1'b1;
      Cmd_Press = 1'b1;
      @(negedge Fg_CLK);
      check("rst_prio", 0, idle_obs());
      RESET = 1'b0;
      idle_cycles(3, "rst_prio_idle");

      cur = mkcmd(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      for (int i = 0; i < 25; i++) begin
         nxt  = mkcmd(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 4)));
         hold = (i != 24) && ($urandom_range(0, 1) == 1);
         run_cmd(cur, hold, nxt, 0, done_cycle(cur), exp_quarters(cur), "rand");
         if (!hold) idle_cycles(int'($urandom_range(0, 3)), "rand_idle");
         cur = nxt;
      end
      idle_cycles(2, "final_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
